// File: rtl/mdll_jm_counter.sv
// Jitter-measurement accumulator: counts 1's on the bang-bang sampler output over a
// window of 2^min(ncycle_jm, CNT_W) reference cycles and holds the count in jm_out.
// Ports: clk/reset (async, active-high); en_jm (async config), ncycle_jm (window exponent),
//        jm_bit (sampler bit); jm_out/jm_valid/jm_busy/jm_done (result and status).
module mdll_jm_counter #(
    parameter int CNT_W = 20,
    parameter int K_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_jm,
    input  logic [K_W-1:0]   ncycle_jm,
    input  logic             jm_bit,
    output logic [CNT_W-1:0] jm_out,
    output logic             jm_valid,
    output logic             jm_busy,
    output logic             jm_done
);

    localparam int K_MAX = CNT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             en_m;
    logic             en_s;
    logic             en_d;
    logic [CNT_W-1:0] acc;
    // One bit wider than the accumulator so the full 2^K_MAX window fits.
    logic [CNT_W:0]   remain;

    logic             start;
    logic [CNT_W:0]   acc_sum;
    logic [CNT_W-1:0] acc_next;
    logic [CNT_W:0]   win_len;
    int               k_eff;

    always_comb begin
        start    = en_s & ~en_d;
        acc_sum  = {1'b0, acc} + {{CNT_W{1'b0}}, jm_bit};
        // Only reachable with the widest window and an all-ones stream.
        acc_next = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
        k_eff    = (int'(ncycle_jm) > K_MAX) ? K_MAX : int'(ncycle_jm);
        win_len  = {{CNT_W{1'b0}}, 1'b1} << k_eff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_m     <= 1'b0;
            en_s     <= 1'b0;
            en_d     <= 1'b0;
            state    <= IDLE;
            acc      <= '0;
            remain   <= '0;
            jm_out   <= '0;
            jm_valid <= 1'b0;
            jm_busy  <= 1'b0;
            jm_done  <= 1'b0;
        end else begin
            en_m    <= en_jm;
            en_s    <= en_m;
            en_d    <= en_s;
            jm_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        // Window length is fixed here; later ncycle_jm changes are ignored.
                        state    <= RUN;
                        remain   <= win_len;
                        acc      <= '0;
                        jm_valid <= 1'b0;
                        jm_busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (!en_s) begin
                        // Abort wins over a coinciding completion; partial count is dropped.
                        state   <= IDLE;
                        jm_busy <= 1'b0;
                    end else if (remain == {{CNT_W{1'b0}}, 1'b1}) begin
                        state    <= DONE;
                        jm_out   <= acc_next;
                        jm_valid <= 1'b1;
                        jm_done  <= 1'b1;
                        jm_busy  <= 1'b0;
                    end else begin
                        acc    <= acc_next;
                        remain <= remain - {{CNT_W{1'b0}}, 1'b1};
                    end
                end

                DONE: begin
                    // Stay here while enabled so a held en_jm gives a single measurement.
                    if (!en_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdll_jm_counter.sv
// Directed + randomized bench for mdll_jm_counter; a narrow counter keeps the clamp window short.
module tb_mdll_jm_counter;

    localparam int CNT_W = 12;
    localparam int K_W   = 6;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             en_jm;
    logic [K_W-1:0]   ncycle_jm;
    logic             jm_bit;
    logic [CNT_W-1:0] jm_out;
    logic             jm_valid;
    logic             jm_busy;
    logic             jm_done;

    int checks   = 0;
    int failures = 0;

    mdll_jm_counter #(.CNT_W(CNT_W), .K_W(K_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en_jm     (en_jm),
        .ncycle_jm (ncycle_jm),
        .jm_bit    (jm_bit),
        .jm_out    (jm_out),
        .jm_valid  (jm_valid),
        .jm_busy   (jm_busy),
        .jm_done   (jm_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pat_bit(input int pat, input int idx);
        case (pat)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (idx % 2) == 0;
            default: return 1'($urandom);
        endcase
    endfunction

    // Called at a negedge; the following posedge is edge N of the timing description.
    // pat: 0 random, 1 all ones, 2 all zeros, 3 alternating starting with 1.
    task automatic measure(input int ncfg, input int pat, input int hold,
                           input logic [31:0] prev, output logic [31:0] result);
        int k, len, ones, busy_n, done_n, done_at, extra_done;
        bit b;
        k       = (ncfg > CNT_W) ? CNT_W : ncfg;
        len     = 1 << k;
        ones    = 0;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        ncycle_jm = K_W'(ncfg);
        en_jm     = 1'b1;
        for (int j = 0; j <= len + 2; j++) begin
            if (j >= 3) begin
                b      = pat_bit(pat, j - 3);
                jm_bit = b;
                ones  += int'(b);
            end else begin
                jm_bit = 1'b1;          // must not be counted before the first sample edge
            end
            if (j == 4) ncycle_jm = K_W'($urandom);
            @(negedge clk);
            if (jm_busy) busy_n++;
            if (jm_done) begin
                done_n++;
                done_at = j;
            end
            if (j == 1) check("busy_before_entry", 32'(jm_busy), 32'd0);
            if (j == 2) begin
                check("valid_clear_on_entry", 32'(jm_valid), 32'd0);
                check("out_held_during_run", 32'(jm_out), prev);
            end
        end
        result = (ones > MAXV) ? MAXV : ones;
        check("jm_out", 32'(jm_out), result);
        check("jm_valid_set", 32'(jm_valid), 32'd1);
        check("busy_cycles", 32'(busy_n), 32'(len));
        check("done_pulses", 32'(done_n), 32'd1);
        check("done_edge", 32'(done_at), 32'(len + 2));
        extra_done = 0;
        for (int j = 0; j < hold; j++) begin
            jm_bit = 1'($urandom);
            @(negedge clk);
            if (jm_done || jm_busy) extra_done++;
        end
        if (hold > 0) check("single_shot", 32'(extra_done), 32'd0);
        en_jm = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(jm_busy), 32'd0);
        check("idle_valid_kept", 32'(jm_valid), 32'd1);
        check("idle_out_kept", 32'(jm_out), result);
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] tmp;
        int abort_done;

        reset     = 1'b1;
        en_jm     = 1'b0;
        ncycle_jm = '0;
        jm_bit    = 1'b0;
        #1;
        check("rst_out", 32'(jm_out), 32'd0);
        check("rst_valid", 32'(jm_valid), 32'd0);
        check("rst_busy", 32'(jm_busy), 32'd0);
        check("rst_done", 32'(jm_done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic count: k=4, 1010... gives 8.
        measure(4, 3, 0, 32'd0, last);
        check("basic_eight", last, 32'd8);

        // Abort: k=6, drop en_jm after 10 samples.
        abort_done = 0;
        ncycle_jm  = 6'd6;
        en_jm      = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            jm_bit = (j >= 3) ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (jm_done) abort_done++;
        end
        en_jm = 1'b0;                   // falls before edge M
        @(negedge clk);
        check("abort_busy_m", 32'(jm_busy), 32'd1);
        @(negedge clk);
        check("abort_busy_m1", 32'(jm_busy), 32'd1);
        @(negedge clk);
        check("abort_busy_m2", 32'(jm_busy), 32'd0);
        check("abort_valid", 32'(jm_valid), 32'd0);
        check("abort_out_kept", 32'(jm_out), last);
        repeat (4) begin
            @(negedge clk);
            if (jm_done || jm_busy) abort_done++;
        end
        check("abort_no_done", 32'(abort_done), 32'd0);

        // Minimum window.
        measure(0, 1, 0, last, last);
        check("k0_ones", last, 32'd1);
        measure(0, 2, 0, last, last);
        check("k0_zeros", last, 32'd0);

        // Randomized windows and bit streams.
        for (int r = 0; r < 6; r++) begin
            measure(int'($urandom_range(0, 7)), 0, 0, last, last);
        end

        // Single shot while en_jm is held for three window lengths, then restart.
        measure(4, 0, 48, last, last);
        measure(4, 0, 0, last, last);

        // Clamp: oversize exponent behaves as the widest window and saturates.
        measure(63, 1, 0, last, tmp);
        check("clamp_63", tmp, 32'(MAXV));
        measure(CNT_W, 1, 0, tmp, last);
        check("clamp_kmax", last, 32'(MAXV));

        // Reset in the middle of a window with en_jm still high.
        ncycle_jm = 6'd5;
        en_jm     = 1'b1;
        repeat (8) begin
            jm_bit = 1'($urandom);
            @(negedge clk);
        end
        check("mid_run_busy", 32'(jm_busy), 32'd1);
        ncycle_jm = 6'd3;
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", 32'(jm_out), 32'd0);
        check("async_rst_valid", 32'(jm_valid), 32'd0);
        check("async_rst_busy", 32'(jm_busy), 32'd0);
        check("async_rst_done", 32'(jm_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        measure(3, 0, 0, 32'd0, last);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
